div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Sequencer for the shared serial divider in the EX stage (RV32M DIV/DIVU/REM/REMU).
//  Accepts one op at a time from EX and resolves divide-by-zero and signed overflow
//  locally with no divider cycles. Returns the other half of the last DIV/REM pair
//  from a one-entry cache, so the divider runs only when needed.
//  Drives start/flush of the divider and returns a registered write-back result.
// PARAMETERS
//  WIDTH  32  operand/result width; the divider instance uses the same WIDTH
// PORTS
//  i_clk            in   1      clock
//  i_rst            in   1      reset, asynchronous, active-low
//  i_flush          in   1      pipeline flush: abort current op
//  i_valid          in   1      EX presents a divide op
//  o_ready          out  1      controller can accept (state IDLE)
//  i_op             in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_rs1 / i_rs2    in   WIDTH  dividend / divisor
//  i_rd             in   5      destination register index
//  o_wb_valid       out  1      one-cycle result pulse
//  o_wb_data        out  WIDTH  result
//  o_wb_rd          out  5      destination of result
//  o_div_start      out  1      one-cycle start pulse to divider
//  o_div_flush      out  1      abort to divider
//  o_div_signed     out  1      signed mode to divider
//  o_div_dividend   out  WIDTH  registered operand to divider
//  o_div_divisor    out  WIDTH  registered operand to divider
//  i_div_end_valid  in   1      divider result valid, single-cycle
//  i_div_quotient   in   WIDTH  divider quotient
//  i_div_remainder  in   WIDTH  divider remainder
// BEHAVIOUR
//  Reset (i_rst=0)
//   - State IDLE; all outputs 0 except o_ready=1; cache invalid.
//  FSM: IDLE, START, WAIT, RESP.
//   - Accept when i_valid & o_ready. Latch op, rs1, rs2 and rd.
//   - Then choose exactly one path, in this priority order:
//     a) Divisor == 0: quotient = all ones, remainder = rs1 -> RESP.
//     b) Signed op with rs1 == 100..0 and rs2 == all ones:
//        quotient = rs1, remainder = 0 -> RESP.
//     c) Cache hit (valid and {rs1, rs2, signed} match): result taken from
//        cached quotient/remainder -> RESP.
//     d) Otherwise -> START.
//   - START: o_div_start=1 for exactly one cycle, operands stable -> WAIT.
//   - WAIT: hold until i_div_end_valid. Then capture quotient/remainder into the
//     result register and the cache, set cache valid -> RESP.
//   - RESP: o_wb_valid=1 for one cycle with o_wb_data/o_wb_rd -> IDLE.
//  Result selection and latency
//   - DIV/DIVU return the quotient; REM/REMU return the remainder.
//   - Fast paths (a/b/c): o_wb_valid 2 cycles after the accept edge.
//   - Divider path: o_wb_valid 1 cycle after i_div_end_valid.
//  Divider interface
//   - o_ready=0 in START/WAIT/RESP; a new op is never issued while the divider is busy.
//   - o_div_signed = ~op[0], held constant from START until the result is captured.
//  Flush
//   - i_flush in any state -> IDLE next cycle; o_wb_valid suppressed that cycle.
//   - In START or WAIT, flush also gives o_div_flush=1 for one cycle. The cache is
//     not written, so a later i_div_end_valid seen in IDLE is ignored.
//   - Flush in the same cycle as i_valid: no accept.
//  Cache
//   - Written only on completion of a divider-path op.
//   - Invalidated by reset only; never by flush.
//  Special-case results are not written to the cache.
// TESTING
//  1. DIV 100/7, rd=5 -> o_div_start once; after end_valid, wb_data=14, wb_rd=5.
//     Then REM 100/7 -> no start, wb_data=2 two cycles after accept.
//  2. DIVU 0xFFFFFFF0/0 -> wb=0xFFFFFFFF. REMU same operands -> wb=0xFFFFFFF0.
//     No o_div_start in either case.
//  3. DIV 0x80000000/0xFFFFFFFF -> wb=0x80000000. REM same -> wb=0, no start.
//  4. DIV -7/2 -> wb=0xFFFFFFFD. Then REMU -7/2 (signedness differs, cache miss)
//     -> start issued, wb=1.
//  5. Flush in WAIT -> o_div_flush pulse, no wb. The next identical DIV misses
//     the cache and restarts the divider.
//  6. Reset asserted in WAIT -> all outputs 0, o_ready=1 immediately.
//     After release, REM of the same operands is a cache miss.

Source files
------------

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl_if : EX request / write-back and serial-divider handshake bundle
// Revision    : 1.0
// ---------------------------------------------------------------------------
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [4:0]       rd;
  logic             wb_valid;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       wb_rd;
  logic             div_start;
  logic             div_flush;
  logic             div_signed;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_end_valid;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  // master: EX stage plus the divider datapath; slave: the controller
  modport master (
    output flush, valid, op, rs1, rs2, rd,
    output div_end_valid, div_quotient, div_remainder,
    input  ready, wb_valid, wb_data, wb_rd,
    input  div_start, div_flush, div_signed, div_dividend, div_divisor
  );

  modport slave (
    input  flush, valid, op, rs1, rs2, rd,
    input  div_end_valid, div_quotient, div_remainder,
    output ready, wb_valid, wb_data, wb_rd,
    output div_start, div_flush, div_signed, div_dividend, div_divisor
  );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl : RV32M divide sequencer with zero/overflow fast paths and a
//            one-entry quotient/remainder cache in front of a serial divider
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  div_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] C_INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic [1:0]       r_op;
  logic             r_wb_valid;
  logic [WIDTH-1:0] r_wb_data;
  logic [4:0]       r_wb_rd;
  logic             r_div_start;
  logic             r_div_flush;
  logic             r_div_signed;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;

  logic             r_cache_valid;
  logic [WIDTH-1:0] r_cache_rs1;
  logic [WIDTH-1:0] r_cache_rs2;
  logic             r_cache_signed;
  logic [WIDTH-1:0] r_cache_quot;
  logic [WIDTH-1:0] r_cache_rem;

  logic             w_signed;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_hit;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_quot;
  logic [WIDTH-1:0] w_fast_rem;

  assign w_signed   = ~bus.op[0];
  assign w_div_zero = (bus.rs2 == '0);
  assign w_overflow = w_signed && (bus.rs1 == C_INT_MIN) && (bus.rs2 == C_ALL_ONES);
  assign w_hit      = r_cache_valid && (r_cache_rs1 == bus.rs1) &&
                      (r_cache_rs2 == bus.rs2) && (r_cache_signed == w_signed);
  assign w_fast     = w_div_zero || w_overflow || w_hit;

  // Priority: divide-by-zero, then signed overflow, then cached pair
  always_comb begin
    w_fast_quot = r_cache_quot;
    w_fast_rem  = r_cache_rem;
    if (w_div_zero) begin
      w_fast_quot = C_ALL_ONES;
      w_fast_rem  = bus.rs1;
    end else if (w_overflow) begin
      w_fast_quot = bus.rs1;
      w_fast_rem  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_ready        <= 1'b1;
      r_op           <= 2'b00;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd        <= 5'd0;
      r_div_start    <= 1'b0;
      r_div_flush    <= 1'b0;
      r_div_signed   <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_cache_valid  <= 1'b0;
      r_cache_rs1    <= '0;
      r_cache_rs2    <= '0;
      r_cache_signed <= 1'b0;
      r_cache_quot   <= '0;
      r_cache_rem    <= '0;
    end else begin
      r_div_start <= 1'b0;
      r_div_flush <= 1'b0;
      if (bus.flush) begin
        r_state     <= S_IDLE;
        r_ready     <= 1'b1;
        r_wb_valid  <= 1'b0;
        r_div_flush <= (r_state == S_START) || (r_state == S_WAIT);
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.valid && r_ready) begin
              r_ready        <= 1'b0;
              r_op           <= bus.op;
              r_wb_rd        <= bus.rd;
              r_div_signed   <= w_signed;
              r_div_dividend <= bus.rs1;
              r_div_divisor  <= bus.rs2;
              if (w_fast) begin
                r_wb_data <= bus.op[1] ? w_fast_rem : w_fast_quot;
                r_state   <= S_RESP;
              end else begin
                r_div_start <= 1'b1;
                r_state     <= S_START;
              end
            end
          end
          S_START: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.div_end_valid) begin
              r_cache_valid  <= 1'b1;
              r_cache_rs1    <= r_div_dividend;
              r_cache_rs2    <= r_div_divisor;
              r_cache_signed <= r_div_signed;
              r_cache_quot   <= bus.div_quotient;
              r_cache_rem    <= bus.div_remainder;
              r_wb_data      <= r_op[1] ? bus.div_remainder : bus.div_quotient;
              r_wb_valid     <= 1'b1;
              r_state        <= S_RESP;
            end
          end
          S_RESP: begin
            // Fast paths arrive with the pulse not yet raised and spend one extra cycle here
            if (r_wb_valid) begin
              r_wb_valid <= 1'b0;
              r_ready    <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_wb_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ready        = r_ready;
  assign bus.wb_valid     = r_wb_valid && !bus.flush;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.div_start    = r_div_start;
  assign bus.div_flush    = r_div_flush;
  assign bus.div_signed   = r_div_signed;
  assign bus.div_dividend = r_div_dividend;
  assign bus.div_divisor  = r_div_divisor;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_ctrl : randomized self-checking bench for div_ctrl against an
//               arithmetic RV32M reference with a modelled one-entry cache
// Revision    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int W = 32;
  localparam logic [W-1:0] C_MIN  = 32'h8000_0000;
  localparam logic [W-1:0] C_ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit           mc_valid = 1'b0;
  logic [W-1:0] mc_a = '0;
  logic [W-1:0] mc_b = '0;
  bit           mc_s = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics straight from the instruction definition
  function automatic void ref_qr(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = C_ONES;
      r = a;
    end else if (!op[0] && a == C_MIN && b == C_ONES) begin
      q = a;
      r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic bit model_fast(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == C_MIN && b == C_ONES) ||
           (mc_valid && mc_a == a && mc_b == b && mc_s == !op[0]);
  endfunction

  task automatic idle_inputs();
    bus.valid         = 1'b0;
    bus.flush         = 1'b0;
    bus.div_end_valid = 1'b0;
    bus.op            = 2'($urandom);
    bus.rs1           = $urandom;
    bus.rs2           = $urandom;
    bus.rd            = 5'($urandom);
    bus.div_quotient  = $urandom;
    bus.div_remainder = $urandom;
  endtask

  // Issues one op and checks every output on every cycle until it retires.
  // flush_at: -1 none, 0 together with valid, n>0 during the n-th cycle after accept.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input int flush_at, input int lat,
                       input bit lit_en, input logic [W-1:0] lit_data, input bit lit_start);
    logic [W-1:0] q, r, exp, dq, dr;
    bit fast, sgn, started;
    int wb_n;
    ref_qr(op, a, b, q, r);
    exp  = op[1] ? r : q;
    sgn  = !op[0];
    fast = model_fast(op, a, b);
    wb_n = fast ? 2 : 2 + lat;
    started = 1'b0;

    chk1("ready_before", bus.ready, 1'b1);
    bus.valid = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    bus.rd    = rd;
    if (flush_at == 0) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      chk1("noaccept_ready", bus.ready, 1'b1);
      chk1("noaccept_start", bus.div_start, 1'b0);
      chk1("noaccept_wb", bus.wb_valid, 1'b0);
      return;
    end
    @(posedge clk); #1;
    idle_inputs();

    for (int n = 1; n <= wb_n; n++) begin
      if (!fast && n == 2 + lat) begin
        mc_valid = 1'b1;
        mc_a     = a;
        mc_b     = b;
        mc_s     = sgn;
      end
      chk1("wb_valid", bus.wb_valid, n == wb_n);
      chk1("ready_busy", bus.ready, 1'b0);
      chk1("div_start", bus.div_start, !fast && n == 1);
      chk1("div_flush_quiet", bus.div_flush, 1'b0);
      if (bus.div_start) started = 1'b1;
      if (!fast && n == 1) begin
        chk("div_dividend", bus.div_dividend, a);
        chk("div_divisor", bus.div_divisor, b);
        chk1("div_signed", bus.div_signed, sgn);
      end
      if (!fast && n > 1 && n < wb_n) chk1("div_signed_hold", bus.div_signed, sgn);
      if (n == wb_n) begin
        chk("wb_data", bus.wb_data, exp);
        chk("wb_rd", W'(bus.wb_rd), W'(rd));
        if (lit_en) chk("wb_literal", bus.wb_data, lit_data);
      end
      if (!fast && n == 1 + lat) begin
        ref_qr({1'b0, !sgn}, a, b, dq, dr);
        bus.div_end_valid = 1'b1;
        bus.div_quotient  = dq;
        bus.div_remainder = dr;
      end
      if (n == flush_at) begin
        bus.flush = 1'b1;
        #1;
        chk1("wb_suppressed", bus.wb_valid, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        chk1("flush_ready", bus.ready, 1'b1);
        chk1("flush_wb", bus.wb_valid, 1'b0);
        chk1("div_flush", bus.div_flush, !fast && n <= 1 + lat);
        @(posedge clk); #1;
        chk1("div_flush_pulse", bus.div_flush, 1'b0);
        return;
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    chk1("ready_after", bus.ready, 1'b1);
    chk1("wb_after", bus.wb_valid, 1'b0);
    if (lit_en) chk1("start_literal", started, lit_start);
  endtask

  logic [W-1:0] pool [8];

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           rf;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready", bus.ready, 1'b1);
    chk1("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_wb_data", bus.wb_data, '0);
    chk("rst_wb_rd", W'(bus.wb_rd), '0);
    chk1("rst_div_start", bus.div_start, 1'b0);
    chk1("rst_div_flush", bus.div_flush, 1'b0);
    chk1("rst_div_signed", bus.div_signed, 1'b0);
    chk("rst_dividend", bus.div_dividend, '0);
    chk("rst_divisor", bus.div_divisor, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    do_op(2'b00, 32'd100, 32'd7, 5'd5, -1, 3, 1'b1, 32'd14, 1'b1);
    do_op(2'b10, 32'd100, 32'd7, 5'd6, -1, 3, 1'b1, 32'd2, 1'b0);
    do_op(2'b01, 32'hFFFF_FFF0, 32'd0, 5'd7, -1, 2, 1'b1, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 5'd8, -1, 2, 1'b1, 32'hFFFF_FFF0, 1'b0);
    do_op(2'b00, C_MIN, C_ONES, 5'd9, -1, 2, 1'b1, 32'h8000_0000, 1'b0);
    do_op(2'b10, C_MIN, C_ONES, 5'd10, -1, 2, 1'b1, 32'd0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd11, -1, 1, 1'b1, 32'hFFFF_FFFD, 1'b1);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd12, -1, 4, 1'b1, 32'd1, 1'b1);

    // Flush in WAIT, stray divider completion in IDLE, then the same op misses
    do_op(2'b00, 32'd1000, 32'd3, 5'd13, 3, 5, 1'b0, '0, 1'b0);
    bus.div_end_valid = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    chk1("stray_end_wb", bus.wb_valid, 1'b0);
    chk1("stray_end_ready", bus.ready, 1'b1);
    @(posedge clk); #1;
    chk1("stray_end_wb2", bus.wb_valid, 1'b0);
    do_op(2'b00, 32'd1000, 32'd3, 5'd14, -1, 2, 1'b1, 32'd333, 1'b1);
    do_op(2'b00, 32'd9, 32'd3, 5'd15, 0, 2, 1'b0, '0, 1'b0);

    // Reset while the divider is busy invalidates the cache
    do_op(2'b00, 32'd50, 32'd3, 5'd16, -1, 2, 1'b1, 32'd16, 1'b1);
    bus.valid = 1'b1;
    bus.op    = 2'b00;
    bus.rs1   = 32'd60;
    bus.rs2   = 32'd7;
    bus.rd    = 5'd17;
    @(posedge clk); #1;
    idle_inputs();
    chk1("pre_rst_start", bus.div_start, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_ready", bus.ready, 1'b1);
    chk1("async_rst_wb", bus.wb_valid, 1'b0);
    chk("async_rst_wb_data", bus.wb_data, '0);
    chk("async_rst_dividend", bus.div_dividend, '0);
    chk1("async_rst_signed", bus.div_signed, 1'b0);
    mc_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b10, 32'd50, 32'd3, 5'd18, -1, 2, 1'b1, 32'd2, 1'b1);
    do_op(2'b10, 32'd60, 32'd7, 5'd19, -1, 1, 1'b1, 32'd4, 1'b1);

    // Randomized traffic biased towards corner operands and cache reuse
    pool[0] = 32'd0;        pool[1] = 32'd1;          pool[2] = 32'd2;  pool[3] = 32'd7;
    pool[4] = C_MIN;        pool[5] = C_ONES;         pool[6] = 32'hFFFF_FFF9; pool[7] = 32'd100;
    for (int i = 0; i < 250; i++) begin
      rop = 2'($urandom);
      if (mc_valid && $urandom_range(0, 9) < 3) begin
        ra = mc_a;
        rb = mc_b;
      end else begin
        ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
        rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      end
      rf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_op(rop, ra, rb, 5'($urandom), rf, int'($urandom_range(1, 5)), 1'b0, '0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk1("idle_gap_wb", bus.wb_valid, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
